mux_route_sched: RTL and testbench

MUX_ROUTE_SCHED -- requirements
Module: mux_route_sched

---
 rtl/mux_route_sched.sv | 161 ++++++++++++++++
 tb/tb_mux_route_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_route_sched.sv
// mux_route_sched
//
// Round-robin scheduler that grants one of four requesting sources,
// captures that source's data bit and routing tag, and drives the data
// bit onto one of four output lanes until downstream accepts it.
//
// Ports:
//   clk       in   1   single clock, rising edge
//   rst       in   1   synchronous active-high reset
//   req       in   4   request per source, held until granted
//   din       in   4   data bit per source
//   tag       in   16  4-bit routing tag per source (tag[4k+3:4k])
//   out_rdy   in   1   downstream accepts the current output
//   gnt       out  4   one-hot grant, one cycle wide
//   sel       out  2   index of the source being served
//   dst       out  2   destination lane for the demux stage
//   out_vld   out  4   one-hot valid on lane dst
//   out_bit   out  4   routed data bit on lane dst
//   busy      out  1   high whenever the FSM is not idle
//   xfer_cnt  out  8   completed transfer count, wraps at 256
//
// Configuration macro: PARITY_ROUTE_EN
//   defined   : dst = sel when the captured tag has odd parity,
//               otherwise the bitwise inverse of sel
//   undefined : dst = sel, tag is not used

module mux_route_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [3:0]  din,
   input  logic [15:0] tag,
   input  logic        out_rdy,
   output logic [3:0]  gnt,
   output logic [1:0]  sel,
   output logic [1:0]  dst,
   output logic [3:0]  out_vld,
   output logic [3:0]  out_bit,
   output logic        busy,
   output logic [7:0]  xfer_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DRIVE = 2'd2
   } state_t;

   state_t      r_state;
   logic [1:0]  r_ptr;
   logic [1:0]  r_winner;
   logic [3:0]  r_gnt;
   logic [1:0]  r_sel;
   logic [1:0]  r_dst;
   logic [3:0]  r_outVld;
   logic [3:0]  r_outBit;
   logic [7:0]  r_xferCnt;

   logic        w_found;
   logic [1:0]  w_winner;
   logic [1:0]  w_idx;
   logic [1:0]  w_dst;

   // Round-robin search starting at the pointer. Walking the offsets from
   // the far end back to zero lets the closest requester overwrite any
   // farther one, so the result is the first hit in ptr, ptr+1, ... order.
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_ptr;
      w_idx    = r_ptr;
      for (int i = 3; i >= 0; i--) begin
         w_idx = r_ptr + 2'(i);
         if (req[w_idx]) begin
            w_found  = 1'b1;
            w_winner = w_idx;
         end
      end
   end

`ifdef PARITY_ROUTE_EN
   logic [3:0]  w_tagSel;

   // The winner's tag is read at the same edge its data bit is captured;
   // odd parity keeps the source lane, even parity mirrors it.
   always_comb begin
      w_tagSel = tag[{r_winner, 2'b00} +: 4];
      w_dst    = (^w_tagSel) ? r_winner : ~r_winner;
   end
`else
   logic [15:0] w_unusedTag;

   // Routing is straight-through; the tag bus is tied to a sink so it
   // carries no logic.
   assign w_unusedTag = tag;

   always_comb begin
      w_dst = r_winner;
   end
`endif

   // Main FSM. Every output is a register so downstream sees clean,
   // glitch-free values. The winner is latched on entry to GRANT so that
   // req changes afterwards cannot disturb the transfer in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ptr     <= 2'd0;
         r_winner  <= 2'd0;
         r_gnt     <= 4'd0;
         r_sel     <= 2'd0;
         r_dst     <= 2'd0;
         r_outVld  <= 4'd0;
         r_outBit  <= 4'd0;
         r_xferCnt <= 8'd0;
      end else begin
         case (r_state)
            IDLE: begin
               r_gnt <= 4'd0;
               if (w_found) begin
                  r_winner <= w_winner;
                  r_gnt    <= 4'b0001 << w_winner;
                  r_state  <= GRANT;
               end
            end
            GRANT: begin
               r_gnt    <= 4'd0;
               r_sel    <= r_winner;
               r_dst    <= w_dst;
               r_ptr    <= r_winner + 2'd1;
               r_outVld <= 4'b0001 << w_dst;
               r_outBit <= {3'b000, din[r_winner]} << w_dst;
               r_state  <= DRIVE;
            end
            DRIVE: begin
               r_gnt <= 4'd0;
               if (out_rdy) begin
                  r_outVld  <= 4'd0;
                  r_outBit  <= 4'd0;
                  r_xferCnt <= r_xferCnt + 8'd1;
                  r_state   <= IDLE;
               end
            end
            default: begin
               r_gnt    <= 4'd0;
               r_outVld <= 4'd0;
               r_outBit <= 4'd0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

   assign gnt      = r_gnt;
   assign sel      = r_sel;
   assign dst      = r_dst;
   assign out_vld  = r_outVld;
   assign out_bit  = r_outBit;
   assign busy     = (r_state != IDLE);
   assign xfer_cnt = r_xferCnt;

endmodule

// File: tb/tb_mux_route_sched.sv
// tb_mux_route_sched
//
// Self-checking bench for mux_route_sched. A transaction-level model
// keeps the round-robin pointer and transfer count and predicts the
// grant, routing and count for each transfer from the scheduling rules.
// Honours PARITY_ROUTE_EN the same way the design does.

module tb_mux_route_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  din;
   logic [15:0] tag;
   logic        out_rdy;
   logic [3:0]  gnt;
   logic [1:0]  sel;
   logic [1:0]  dst;
   logic [3:0]  out_vld;
   logic [3:0]  out_bit;
   logic        busy;
   logic [7:0]  xfer_cnt;

   int nChecks;
   int nPass;
   int mPtr;
   int mCnt;

   mux_route_sched dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .din      (din),
      .tag      (tag),
      .out_rdy  (out_rdy),
      .gnt      (gnt),
      .sel      (sel),
      .dst      (dst),
      .out_vld  (out_vld),
      .out_bit  (out_bit),
      .busy     (busy),
      .xfer_cnt (xfer_cnt)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports misses.
   task automatic checkOutput(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
      nChecks++;
      if (observed === expected) nPass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, observed, expected);
   endtask

   // Advance one clock and settle just past the edge before sampling.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Every output must be at its reset value.
   task automatic checkCleared(input string name);
      checkOutput({name, "Gnt"}, 32'(gnt), 32'd0);
      checkOutput({name, "Sel"}, 32'(sel), 32'd0);
      checkOutput({name, "Dst"}, 32'(dst), 32'd0);
      checkOutput({name, "Vld"}, 32'(out_vld), 32'd0);
      checkOutput({name, "Bit"}, 32'(out_bit), 32'd0);
      checkOutput({name, "Busy"}, 32'(busy), 32'd0);
      checkOutput({name, "Cnt"}, 32'(xfer_cnt), 32'd0);
   endtask

   task automatic applyReset;
      rst     = 1'b1;
      req     = 4'd0;
      din     = 4'd0;
      tag     = 16'd0;
      out_rdy = 1'b0;
      step;
      step;
      rst  = 1'b0;
      mPtr = 0;
      mCnt = 0;
      checkCleared("reset");
   endtask

   // One scheduling attempt from IDLE: present r/d/t, predict the winner,
   // then hold downstream not-ready for 'stall' cycles before accepting.
   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d,
                                input logic [15:0] t, input int stall);
      int         k;
      int         expDst;
      bit         found;
      logic [3:0] expVld;
      logic [3:0] expBit;
      logic [3:0] tagK;

      req     = r;
      din     = d;
      tag     = t;
      out_rdy = 1'($urandom_range(0, 1));
      found   = 1'b0;
      k       = 0;
      for (int i = 0; i < 4; i++) begin
         if (!found && r[(mPtr + i) % 4]) begin
            found = 1'b1;
            k     = (mPtr + i) % 4;
         end
      end
      step;
      if (!found) begin
         checkOutput("idleBusy", 32'(busy), 32'd0);
         checkOutput("idleGnt", 32'(gnt), 32'd0);
         req = 4'd0;
         return;
      end
      checkOutput("gnt", 32'(gnt), 32'(1 << k));
      checkOutput("grantBusy", 32'(busy), 32'd1);
      req = 4'($urandom);
      step;

      tagK = t[4*k +: 4];
`ifdef PARITY_ROUTE_EN
      expDst = (^tagK) ? k : 3 - k;
`else
      expDst = k;
`endif
      expVld = 4'(1 << expDst);
      expBit = d[k] ? expVld : 4'd0;
      mPtr   = (k + 1) % 4;

      for (int s = 0; s <= stall; s++) begin
         checkOutput("driveGnt", 32'(gnt), 32'd0);
         checkOutput("driveSel", 32'(sel), 32'(k));
         checkOutput("driveDst", 32'(dst), 32'(expDst));
         checkOutput("driveVld", 32'(out_vld), 32'(expVld));
         checkOutput("driveBit", 32'(out_bit), 32'(expBit));
         checkOutput("driveBusy", 32'(busy), 32'd1);
         din     = 4'($urandom);
         tag     = 16'($urandom);
         req     = 4'($urandom);
         out_rdy = (s == stall);
         step;
      end
      mCnt = (mCnt + 1) % 256;
      checkOutput("doneVld", 32'(out_vld), 32'd0);
      checkOutput("doneBusy", 32'(busy), 32'd0);
      checkOutput("doneCnt", 32'(xfer_cnt), 32'(mCnt));
      req     = 4'd0;
      out_rdy = 1'b0;
   endtask

   initial begin
      nChecks = 0;
      nPass   = 0;
      applyReset;

      // Single source 2, odd-parity tag: lane 2 either way.
      applyStimulus(4'b0100, 4'b0100, 16'h0700, 0);
      checkOutput("firstCnt", 32'(xfer_cnt), 32'd1);

      // Even-parity tag: lane 1 with routing, lane 2 without.
      applyReset;
      applyStimulus(4'b0100, 4'b0100, 16'h0300, 0);

      // All four requesting from reset: strict rotation, eight transfers.
      applyReset;
      for (int i = 0; i < 8; i++)
         applyStimulus(4'b1111, 4'($urandom), 16'($urandom), 0);
      checkOutput("rotateCnt", 32'(xfer_cnt), 32'd8);

      // Downstream stalls five cycles, output must hold.
      applyStimulus(4'b1000, 4'b1000, 16'h1000, 5);
      checkOutput("stallCnt", 32'(xfer_cnt), 32'd9);

      // Reset in the middle of DRIVE drops the transfer.
      req     = 4'b0010;
      din     = 4'hF;
      tag     = 16'h0000;
      out_rdy = 1'b0;
      step;
      req = 4'd0;
      step;
      checkOutput("preRstBusy", 32'(busy), 32'd1);
      rst = 1'b1;
      step;
      rst  = 1'b0;
      mPtr = 0;
      mCnt = 0;
      checkCleared("midRst");
      applyStimulus(4'b1111, 4'($urandom), 16'($urandom), 0);

      // Random traffic including idle cycles and stalls.
      for (int i = 0; i < 40; i++)
         applyStimulus(4'($urandom), 4'($urandom), 16'($urandom),
                       int'($urandom_range(0, 3)));

      // Counter wrap after exactly 256 transfers.
      applyReset;
      for (int i = 0; i < 256; i++)
         applyStimulus(4'($urandom_range(1, 15)), 4'($urandom), 16'($urandom), 0);
      checkOutput("wrapCnt", 32'(xfer_cnt), 32'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
